// File: rtl/hex_disp_pkg.sv
// Shared definitions for the six-digit hex display arbiter.
// Consumed by hex7seg_dec and hex_disp_arb through import hex_disp_pkg::*.
package hex_disp_pkg;

    // Display geometry and the all-segments-off pattern (active-low drives).
    localparam int         NUM_DIGITS  = 6;
    localparam int         DIGIT_IDX_W = 3;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    // Layout of the 6-bit write data carried by each requester.
    localparam int DATA_W         = 6;
    localparam int DATA_NIB_LSB   = 0;
    localparam int DATA_NIB_MSB   = 3;
    localparam int DATA_BLANK_BIT = 4;
    localparam int DATA_BLINK_BIT = 5;

    // Round-robin bookkeeping: which requester was granted most recently.
    localparam logic GRANT_REQ0 = 1'b0;
    localparam logic GRANT_REQ1 = 1'b1;

    // One stored display digit.
    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       blink;
    } digit_rec_t;

    localparam digit_rec_t DIGIT_RESET = '{nibble: 4'h0, blank: 1'b1, blink: 1'b0};

    // Convert requester write data into a digit record. The blink bit is
    // only kept when the blink feature is built in.
    function automatic digit_rec_t unpack_data(input logic [DATA_W-1:0] data,
                                               input logic              blink_en);
        digit_rec_t rec;
        rec.nibble = data[DATA_NIB_MSB:DATA_NIB_LSB];
        rec.blank  = data[DATA_BLANK_BIT];
        rec.blink  = data[DATA_BLINK_BIT] & blink_en;
        return rec;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to seven-segment decoder.
// Output is active-low, ordered {g,f,e,d,c,b,a}.
module hex7seg_dec
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Standard hex glyphs 0-9, A, b, C, d, E, F.
    always_comb begin
        // NOTE: a default before the case keeps the block purely combinational
        // even if an arm is ever removed; without it a latch would be inferred.
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_disp_arb.sv
// Two-requester round-robin arbiter writing a six-digit seven-segment display.
// Optional feature: define HEX_DISP_BLINK_EN to build the per-digit blink
// logic (counter of BLINK_DIV cycles per half-period plus a phase flop).
// Without it, data bit [5] is ignored and no blink logic exists.
module hex_disp_arb
    import hex_disp_pkg::*;
#(
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   CLK,
    input  logic                   RST,

    input  logic                   req0_valid,
    input  logic [DIGIT_IDX_W-1:0] req0_digit,
    input  logic [DATA_W-1:0]      req0_data,
    output logic                   req0_ready,

    input  logic                   req1_valid,
    input  logic [DIGIT_IDX_W-1:0] req1_digit,
    input  logic [DATA_W-1:0]      req1_data,
    output logic                   req1_ready,

    output logic [6:0]             HEX0,
    output logic [6:0]             HEX1,
    output logic [6:0]             HEX2,
    output logic [6:0]             HEX3,
    output logic [6:0]             HEX4,
    output logic [6:0]             HEX5
);

`ifdef HEX_DISP_BLINK_EN
    localparam logic BLINK_EN = 1'b1;
`else
    localparam logic BLINK_EN = 1'b0;
`endif

    logic                   last_grant_q, last_grant_d;
    digit_rec_t             digit_q [NUM_DIGITS];
    digit_rec_t             digit_d [NUM_DIGITS];
    logic [6:0]             hex_q   [NUM_DIGITS];
    logic [6:0]             hex_d   [NUM_DIGITS];
    logic [6:0]             seg_raw [NUM_DIGITS];

    logic                   gnt0, gnt1, xfer;
    logic [DIGIT_IDX_W-1:0] sel_digit;
    logic [DATA_W-1:0]      sel_data;
    logic                   blink_phase;

    // Grant selection: a lone requester wins; under contention the one not
    // granted last wins. Nothing is granted while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            if (req0_valid && (!req1_valid || last_grant_q == GRANT_REQ1)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;
    assign sel_digit  = gnt1 ? req1_digit : req0_digit;
    assign sel_data   = gnt1 ? req1_data  : req0_data;

    // Next digit-register state: the granted write lands in the addressed
    // digit; indices 6 and 7 match no register and are silently dropped.
    always_comb begin
        last_grant_d = last_grant_q;
        digit_d      = digit_q;
        if (xfer) begin
            last_grant_d = gnt1 ? GRANT_REQ1 : GRANT_REQ0;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (xfer && sel_digit == DIGIT_IDX_W'(i)) begin
                digit_d[i] = unpack_data(sel_data, BLINK_EN);
            end
        end
    end

`ifdef HEX_DISP_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    // Blink timebase: count 0..BLINK_DIV-1 and flip the phase on each wrap.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + CNT_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Blink timebase registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;
`else
    assign blink_phase = 1'b0;
`endif

    // One glyph decoder per digit.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex7seg_dec u_dec (
            .nibble (digit_q[g].nibble),
            .seg    (seg_raw[g])
        );
    end

    // Output pattern per digit: blanked digits and digits in the off half of
    // a blink show all segments off, otherwise the decoded glyph.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q[i].blank || (digit_q[i].blink && blink_phase)) begin
                hex_d[i] = SEG_BLANK;
            end else begin
                hex_d[i] = seg_raw[i];
            end
        end
    end

    // Arbiter, digit and registered segment state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant_q <= GRANT_REQ1;
            // NOTE: these arrays are six small register banks, not a RAM, so
            // every entry is reset explicitly to a known blanked display.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= DIGIT_RESET;
                hex_q[i]   <= SEG_BLANK;
            end
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            last_grant_q <= last_grant_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
                hex_q[i]   <= hex_d[i];
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: doc/hex_disp_arb.md
HEX_DISP_ARB -- requirements
Module: hex_disp_arb

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, meaning CLK cycles per blink half-period (minimum 2).
REQ-002 SHALL have port CLK, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req0_valid, input, 1, requester 0 (CPU PIO) write request.
REQ-005 SHALL have port req0_digit, input, 3, requester 0 target digit index (0..5).
REQ-006 SHALL have port req0_data, input, 6: [3:0] hex nibble, [4] blank, [5] blink.
REQ-007 SHALL have port req0_ready, output, 1, requester 0 grant; a transfer occurs on an edge where valid and ready are both 1.
REQ-008 SHALL have ports req1_valid, req1_digit, req1_data, req1_ready, identical to requester 0, for requester 1 (switch monitor).
REQ-009 SHALL have ports HEX0..HEX5, output, 7 each, active-low segment drives {g,f,e,d,c,b,a}.

Function
REQ-010 SHALL keep six digit registers, each {nibble[3:0], blank, blink}.
REQ-011 SHALL arbitrate round-robin via a 1-bit last_grant state: with only one valid, that requester gets ready; with both valid, the requester not granted last gets ready.
REQ-012 SHALL assert at most one readyN per cycle; readyN SHALL be 0 when reqN_valid is 0 (readyN may depend combinationally on valids).
REQ-013 SHALL, on an accepted transfer, write the granted requester's data into the addressed digit register at that edge and update last_grant to the granted requester.
REQ-014 SHALL accept and discard transfers with digit index 6 or 7 (ready still asserted, no register change, last_grant still updated).
REQ-015 SHALL register HEXn outputs: HEXn reflects digit register n one edge after it is written (acceptance edge N -> HEX valid after edge N+1).
REQ-016 SHALL drive 7'h7F for a digit whose blank bit is 1; otherwise standard hex 0-F patterns (e.g. 0 -> 7'h40, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E).
REQ-017 SHALL sustain one accepted transfer per cycle; a requester holding valid while the other is also valid is served every second cycle.
REQ-018 SHALL treat requesters as holding valid/digit/data stable until accepted; behaviour otherwise is unspecified beyond REQ-012.

Reset
REQ-019 SHALL, while RST=1 at an edge, set all digit registers to blank=1, nibble=0, blink=0.
REQ-020 SHALL, while RST=1 at an edge, set HEX0..HEX5 to 7'h7F, last_grant to requester 1 (so requester 0 wins the first contention), blink counter to 0, blink phase to 0.
REQ-021 SHALL hold req0_ready and req1_ready at 0 while RST=1; a transfer in the reset cycle is dropped.

Configuration
REQ-022 SHALL implement blinking only when HEX_DISP_BLINK_EN is defined.
REQ-023 With HEX_DISP_BLINK_EN: counter counts 0..BLINK_DIV-1 and wraps, toggling blink phase on wrap; while phase=1 any digit with blink=1 outputs 7'h7F.
REQ-024 Without HEX_DISP_BLINK_EN: no counter or phase logic, data bit [5] ignored, stored blink bit always 0.

Structure
REQ-025 SHALL place in shared package hex_disp_pkg: NUM_DIGITS=6, SEG_BLANK=7'h7F, digit-record typedef {nibble, blank, blink}, data field bit positions.
REQ-026 SHALL use one combinational sub-module hex7seg_dec (4-bit nibble -> 7-bit active-low segments), instantiated once per digit.

Verification
REQ-027 Reset: RST=1 two cycles -> all HEXn=7'h7F, both ready=0; release -> still 7'h7F.
REQ-028 Single write: req0 digit=2 data=6'h05 -> req0_ready=1 that cycle, HEX2=7'h12 one edge after acceptance, other HEXn unchanged.
REQ-029 Contention: both valid continuously after reset, req0 digit0 data 1, req1 digit1 data 3 -> grants alternate 0,1,0,1; HEX0=7'h79, HEX1=7'h30.
REQ-030 Invalid index: req1 digit=7 data=6'h08 -> accepted, all HEXn unchanged; next contention grants req0.
REQ-031 Blank: write digit 4 data 6'h1F -> HEX4=7'h7F; then data 6'h0F -> HEX4=7'h0E.
REQ-032 Blink (BLINK_DIV=4, macro defined): digit 5 data 6'h28 -> HEX5 alternates 7'h00 / 7'h7F every 4 cycles; macro undefined -> HEX5 steady 7'h00.
